// File: rtl/sensor_hub_dispatcher.sv
`timescale 1ns/1ps
// Purpose : decodes (command, address) requests, runs single or continuous DHT11-class
//           measurements on one of NUM_SENSORS channels and returns one response per request.
// Latency : non-measuring request accepted in T -> resp_valid in T+2 (T+1 when accepted in LOOP_WAIT);
//           measuring request -> resp_valid the cycle after sensor_done or timeout.
// Backpressure: req_ready only in IDLE/LOOP_WAIT; a response is held unchanged until resp_ready.
// Ports   : clock/reset (sync, active-high); req_* request handshake with command/address;
//           sensor_enable/done/error/temp/hum per-channel sensor side (packed DATA_WIDTH slices);
//           resp_* response handshake with command/value/address; continuous_active loop status.
module sensor_hub_dispatcher #(
  parameter int NUM_SENSORS    = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int LOOP_PERIOD    = 50000000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [7:0]                        request_command,
  input  logic [7:0]                        request_address,
  output logic [NUM_SENSORS-1:0]            sensor_enable,
  input  logic [NUM_SENSORS-1:0]            sensor_done,
  input  logic [NUM_SENSORS-1:0]            sensor_error,
  input  logic [NUM_SENSORS*DATA_WIDTH-1:0] sensor_temp,
  input  logic [NUM_SENSORS*DATA_WIDTH-1:0] sensor_hum,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [7:0]                        response_command,
  output logic [DATA_WIDTH-1:0]             response_value,
  output logic [7:0]                        response_address,
  output logic                              continuous_active
);

  localparam int AW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int PW = $clog2(LOOP_PERIOD);

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PER_LAST = PW'(LOOP_PERIOD - 1);
  localparam logic [7:0]    NUM_CH   = 8'(NUM_SENSORS);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_MEASURE   = 3'd2;
  localparam logic [2:0] S_RESPOND   = 3'd3;
  localparam logic [2:0] S_LOOP_WAIT = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;      // also the loop's command while continuous
  logic [7:0]            addr_q, addr_d;    // also the loop's channel while continuous
  logic                  cont_q, cont_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [PW-1:0]         per_q, per_d;
  logic [7:0]            rcmd_q, rcmd_d;
  logic [DATA_WIDTH-1:0] rval_q, rval_d;
  logic [7:0]            raddr_q, raddr_d;

  logic                  accept;
  logic                  stop_match;
  logic [AW-1:0]         sel;
  logic [DATA_WIDTH-1:0] temp_arr [NUM_SENSORS];
  logic [DATA_WIDTH-1:0] hum_arr  [NUM_SENSORS];

  always_comb begin
    for (int i = 0; i < NUM_SENSORS; i++) begin
      temp_arr[i] = sensor_temp[i*DATA_WIDTH +: DATA_WIDTH];
      hum_arr[i]  = sensor_hum[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Only meaningful in MEASURE, where DECODE has already rejected out-of-range addresses.
  assign sel = addr_q[AW-1:0];

  // Reset also gates req_ready so nothing is accepted while reset is held.
  assign req_ready  = !reset && ((state_q == S_IDLE) || (state_q == S_LOOP_WAIT));
  assign accept     = req_valid && req_ready;
  assign stop_match = ((request_command == 8'h05) && (cmd_q == 8'h03)) ||
                      ((request_command == 8'h06) && (cmd_q == 8'h04));

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    cont_d  = cont_q;
    tmo_d   = tmo_q;
    per_d   = per_q;
    rcmd_d  = rcmd_q;
    rval_d  = rval_q;
    raddr_d = raddr_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cmd_d   = request_command;
          addr_d  = request_address;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        raddr_d = addr_q;
        state_d = S_RESPOND;
        if (addr_q >= NUM_CH) begin
          rcmd_d = 8'hEF;
          rval_d = DATA_WIDTH'(8'hEF);
        end else if (cmd_q <= 8'h04) begin
          tmo_d   = '0;
          state_d = S_MEASURE;
        end else if ((cmd_q == 8'h05) || (cmd_q == 8'h06)) begin
          rcmd_d = 8'hAA;
          rval_d = DATA_WIDTH'(8'hAA);
        end else begin
          rcmd_d = 8'h0F;
          rval_d = DATA_WIDTH'(8'h0F);
        end
      end

      S_MEASURE: begin
        raddr_d = addr_q;
        if (sensor_done[sel]) begin
          state_d = S_RESPOND;
          if (sensor_error[sel]) begin
            rcmd_d = 8'h1F;
            rval_d = DATA_WIDTH'(8'h1F);
          end else begin
            case (cmd_q)
              8'h01, 8'h03: begin
                rcmd_d = 8'h09;
                rval_d = temp_arr[sel];
              end
              8'h02, 8'h04: begin
                rcmd_d = 8'h08;
                rval_d = hum_arr[sel];
              end
              default: begin
                rcmd_d = 8'h07;
                rval_d = DATA_WIDTH'(8'h07);
              end
            endcase
            // Loop starts only after a clean first measurement.
            if ((cmd_q == 8'h03) || (cmd_q == 8'h04)) cont_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Enable has now been held TIMEOUT_CYCLES cycles.
          state_d = S_RESPOND;
          rcmd_d  = 8'h1F;
          rval_d  = DATA_WIDTH'(8'h1F);
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_RESPOND: begin
        if (resp_ready) begin
          per_d   = '0;
          state_d = cont_q ? S_LOOP_WAIT : S_IDLE;
        end
      end

      S_LOOP_WAIT: begin
        // A request beats period expiry; cmd_q/addr_q keep the loop's own command.
        if (accept) begin
          state_d = S_RESPOND;
          raddr_d = request_address;
          if (stop_match) begin
            cont_d = 1'b0;
            rcmd_d = 8'h0A;
            rval_d = '0;
          end else begin
            rcmd_d = 8'hFF;
            rval_d = DATA_WIDTH'(8'hFF);
          end
        end else if (per_q == PER_LAST) begin
          tmo_d   = '0;
          state_d = S_MEASURE;
        end else begin
          per_d = per_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      cont_q  <= 1'b0;
      tmo_q   <= '0;
      per_q   <= '0;
      rcmd_q  <= '0;
      rval_q  <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      cont_q  <= cont_d;
      tmo_q   <= tmo_d;
      per_q   <= per_d;
      rcmd_q  <= rcmd_d;
      rval_q  <= rval_d;
      raddr_q <= raddr_d;
    end
  end

  always_comb begin
    sensor_enable = '0;
    if (state_q == S_MEASURE) sensor_enable[sel] = 1'b1;
  end

  assign resp_valid        = (state_q == S_RESPOND);
  assign response_command  = resp_valid ? rcmd_q  : '0;
  assign response_value    = resp_valid ? rval_q  : '0;
  assign response_address  = resp_valid ? raddr_q : '0;
  assign continuous_active = cont_q;

endmodule
